// File: rtl/xcvr_spi_slave.sv
// xcvr_spi_slave: SPI slave transceiver (all SPI modes) with TX/RX byte FIFOs
//   clk/nRst            system clock, synchronous active-low reset
//   dataIn/write        push a byte into the TX FIFO
//   read/dataOut        pop / head of the RX FIFO
//   cpol/cpha           SPI mode, static while nCs is low
//   sck/mosi/nCs        asynchronous SPI pins from the master
//   miso/misoEn         registered MISO and its tristate enable
//   tx*/rx* status      FIFO data present / half full / full
//   txUnderrun          pulse: empty TX FIFO, 0x00 sent instead
//   rxOverflow          pulse: received byte dropped, RX FIFO full
module Fifo #(
  parameter int LOG2_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] dataIn,
  input  logic       write,
  input  logic       read,
  output logic [7:0] dataOut,
  output logic       dataPresent,
  output logic       halfFull,
  output logic       full
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  logic [7:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wrPtr, rdPtr;
  logic [LOG2_DEPTH:0] count;
  logic doWrite, doRead;
  always_comb begin
    dataPresent = count != '0;
    full = count[LOG2_DEPTH];
    halfFull = count[LOG2_DEPTH] || count[LOG2_DEPTH-1];
    doRead = read && dataPresent;
    doWrite = write && (!full || doRead);
    dataOut = mem[rdPtr];
  end
  always_ff @(posedge clk)
    if (doWrite) mem[wrPtr] <= dataIn;
  always_ff @(posedge clk) begin
    if (!nRst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead) rdPtr <= rdPtr + 1'b1;
      count <= count + (LOG2_DEPTH+1)'(doWrite) - (LOG2_DEPTH+1)'(doRead);
    end
  end
endmodule

module xcvr_spi_slave #(
  parameter int LOG2_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] dataIn,
  input  logic       write,
  input  logic       read,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sck,
  input  logic       mosi,
  input  logic       nCs,
  output logic       miso,
  output logic       misoEn,
  output logic       txDataPresent,
  output logic       txHalfFull,
  output logic       txFull,
  output logic       rxDataPresent,
  output logic       rxHalfFull,
  output logic       rxFull,
  output logic [7:0] dataOut,
  output logic       txUnderrun,
  output logic       rxOverflow
);
  typedef enum logic [1:0] {sIdle, sArmed, sActive} stateT;
  stateT state, nextState;
  logic [2:0] sckS, bitCnt;
  logic [1:0] mosiS, nCsS, live;
  logic [7:0] txShift, txHead, nextByte, rxByte;
  logic [6:0] rxShift;
  logic lead, trail, start, stop, run, sampleEv, shiftEv, lastBit, load, txRead, rxWrite;
  Fifo #(.LOG2_DEPTH(LOG2_DEPTH)) txFifo (
    .clk(clk), .nRst(nRst), .dataIn(dataIn), .write(write), .read(txRead),
    .dataOut(txHead), .dataPresent(txDataPresent), .halfFull(txHalfFull), .full(txFull)
  );
  Fifo #(.LOG2_DEPTH(LOG2_DEPTH)) rxFifo (
    .clk(clk), .nRst(nRst), .dataIn(rxByte), .write(rxWrite), .read(read),
    .dataOut(dataOut), .dataPresent(rxDataPresent), .halfFull(rxHalfFull), .full(rxFull)
  );
  // live marks the synchronizers as holding real pin values rather than their
  // reset values, so a low nCs at reset release cannot be mistaken for a fresh frame
  always_comb begin
    lead = sckS[2] == cpol && sckS[1] != cpol;
    trail = sckS[2] != cpol && sckS[1] == cpol;
    start = state == sArmed && !nCsS[1];
    stop = state == sActive && nCsS[1];
    run = state == sActive && !nCsS[1];
    sampleEv = run && (cpha ? trail : lead);
    shiftEv = run && (cpha ? lead : trail);
    lastBit = sampleEv && bitCnt == 3'd7;
    load = start || lastBit;
    txRead = load && txDataPresent;
    nextByte = txDataPresent ? txHead : 8'h00;
    rxByte = {rxShift, mosiS[1]};
    rxWrite = lastBit && !rxFull;
    misoEn = state == sActive;
    nextState = state == sIdle ? (live[1] && nCsS[1] ? sArmed : sIdle) :
                start ? sActive : stop ? sArmed : state;
  end
  always_ff @(posedge clk)
    state <= !nRst ? sIdle : nextState;
  always_ff @(posedge clk) begin
    if (!nRst) begin
      sckS <= {3{cpol}};
      mosiS <= '0;
      nCsS <= '1;
      live <= '0;
      bitCnt <= '0;
      txShift <= '0;
      rxShift <= '0;
      miso <= 1'b0;
      txUnderrun <= 1'b0;
      rxOverflow <= 1'b0;
    end else begin
      sckS <= {sckS[1:0], sck};
      mosiS <= {mosiS[0], mosi};
      nCsS <= {nCsS[0], nCs};
      live <= {live[0], 1'b1};
      txUnderrun <= load && !txDataPresent;
      rxOverflow <= lastBit && rxFull;
      if (start || stop) bitCnt <= '0;
      else if (sampleEv) bitCnt <= bitCnt + 3'd1;
      if (sampleEv) rxShift <= {rxShift[5:0], mosiS[1]};
      if (stop) miso <= 1'b0;
      else if (start && !cpha) miso <= nextByte[7];
      else if (shiftEv) miso <= txShift[7];
      // with cpha=0 the MSB goes straight out at frame start, so it is pre-shifted away
      if (load) txShift <= start && !cpha ? {nextByte[6:0], 1'b0} : nextByte;
      else if (shiftEv) txShift <= {txShift[6:0], 1'b0};
    end
  end
endmodule

// File: tb/tb_xcvr_spi_slave.sv
// tb_xcvr_spi_slave: scoreboard bench driving a behavioural SPI master against xcvr_spi_slave
module tb_xcvr_spi_slave;
  localparam int DEPTH = 16;
  localparam int H = 5;
  logic clk, nRst, write, read, cpol, cpha, sck, mosi, nCs;
  logic [7:0] dataIn, dataOut;
  logic miso, misoEn, txDataPresent, txHalfFull, txFull, rxDataPresent, rxHalfFull, rxFull;
  logic txUnderrun, rxOverflow;
  xcvr_spi_slave #(.LOG2_DEPTH(4)) dut (
    .clk(clk), .nRst(nRst), .dataIn(dataIn), .write(write), .read(read),
    .cpol(cpol), .cpha(cpha), .sck(sck), .mosi(mosi), .nCs(nCs),
    .miso(miso), .misoEn(misoEn), .txDataPresent(txDataPresent), .txHalfFull(txHalfFull),
    .txFull(txFull), .rxDataPresent(rxDataPresent), .rxHalfFull(rxHalfFull), .rxFull(rxFull),
    .dataOut(dataOut), .txUnderrun(txUnderrun), .rxOverflow(rxOverflow)
  );
  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } reqT;
  reqT reqQ[$];
  logic [7:0] txModel[$], rxModel[$], moQ[$];
  logic [31:0] expMiso[$], obsMiso[$];
  logic [7:0] cur;
  int checks = 0, failures = 0;
  int expUnder = 0, expOvf = 0, seenUnder = 0, seenOvf = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: the only process that compares and counts
  always @(negedge clk) begin
    while (reqQ.size() > 0) begin
      reqT r;
      r = reqQ.pop_front();
      cmp(r.name, r.act, r.exp);
    end
    if (nRst) begin
      if (txUnderrun) seenUnder++;
      if (rxOverflow) seenOvf++;
      if (read && rxDataPresent)
        cmp("rx_byte", {24'h0, dataOut}, rxModel.size() > 0 ? {24'h0, rxModel.pop_front()} : 32'hDEADBEEF);
      while (obsMiso.size() > 0)
        cmp("miso_byte", obsMiso.pop_front(), expMiso.size() > 0 ? expMiso.pop_front() : 32'hDEADBEEF);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    reqQ.push_back('{name, act, exp});
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] loadTx();
    if (txModel.size() > 0) return txModel.pop_front();
    expUnder++;
    return 8'h00;
  endfunction

  task automatic wr(input logic [7:0] b);
    dataIn = b;
    write = 1;
    waitClk(1);
    write = 0;
    if (txModel.size() < DEPTH) txModel.push_back(b);
  endtask

  task automatic setMode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sck = p;
    waitClk(4);
  endtask

  task automatic csLow(input bit act);
    nCs = 0;
    waitClk(2);
    chk("en_early", misoEn, 0);
    waitClk(1);
    chk("en_on", misoEn, act);
    if (act) cur = loadTx();
    waitClk(3);
  endtask

  task automatic bits(input int n, input bit act);
    logic [7:0] mi = 0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] cb;
      logic b, mb;
      cb = moQ[i / 8];
      b = cb[7 - (i % 8)];
      if (!cpha) begin
        mosi = b;
        waitClk(H);
        mb = miso;
        sck = ~cpol;
        waitClk(H);
        sck = cpol;
      end else begin
        waitClk(H);
        sck = ~cpol;
        mosi = b;
        waitClk(H);
        mb = miso;
        sck = cpol;
      end
      mi = {mi[6:0], mb};
      if (act && i % 8 == 7) begin
        expMiso.push_back({24'h0, cur});
        obsMiso.push_back({24'h0, mi});
        if (rxModel.size() < DEPTH) rxModel.push_back(cb);
        else expOvf++;
        cur = loadTx();
      end
    end
  endtask

  task automatic csHigh(input bit act);
    waitClk(6);
    chk("en_held", misoEn, act);
    nCs = 1;
    waitClk(3);
    chk("en_off", {misoEn, miso}, 0);
    waitClk(5);
  endtask

  task automatic frame(input int n);
    csLow(1);
    bits(n, 1);
    csHigh(1);
  endtask

  task automatic flags();
    chk("underrun_cnt", seenUnder, expUnder);
    chk("overflow_cnt", seenOvf, expOvf);
  endtask

  task automatic drain();
    int g = 0;
    while (rxDataPresent && g < 40) begin
      read = 1;
      waitClk(1);
      read = 0;
      waitClk(1);
      g++;
    end
    chk("rx_left", rxModel.size(), 0);
    chk("rx_present", rxDataPresent, 0);
  endtask

  task automatic fillMo(input int n);
    moQ.delete();
    for (int i = 0; i < n; i++) moQ.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    nRst = 0; nCs = 1; sck = 0; mosi = 0; cpol = 0; cpha = 0;
    write = 0; read = 0; dataIn = 0;
    waitClk(3);
    chk("reset_outputs", {miso, misoEn, txUnderrun, rxOverflow, txDataPresent, txHalfFull,
        txFull, rxDataPresent, rxHalfFull, rxFull}, 0);
    nRst = 1;
    waitClk(4);
    wr(8'hA5);
    moQ = '{8'h3C};
    frame(8);
    chk("mode0_rx_present", rxDataPresent, 1);
    chk("mode0_head", dataOut, 8'h3C);
    drain();
    flags();
    for (int m = 0; m < 4; m++) begin
      setMode(m[1], m[0]);
      wr(8'h01); wr(8'h80); wr(8'hFF);
      moQ = '{8'h55, 8'hAA, 8'h0F};
      frame(24);
      drain();
      flags();
    end
    setMode(0, 1);
    fillMo(2);
    frame(16);
    drain();
    flags();
    setMode(1, 0);
    fillMo(DEPTH);
    frame(8 * DEPTH);
    chk("rx_full", rxFull, 1);
    chk("rx_half", rxHalfFull, 1);
    moQ = '{8'h77};
    frame(8);
    chk("rx_full_kept", rxFull, 1);
    flags();
    drain();
    setMode(0, 0);
    moQ = '{8'h5A};
    csLow(1);
    bits(4, 1);
    csHigh(1);
    chk("abort_no_push", rxDataPresent, 0);
    moQ = '{8'hC3};
    frame(8);
    drain();
    flags();
    fillMo(2);
    csLow(1);
    bits(3, 1);
    nRst = 0;
    waitClk(2);
    nRst = 1;
    txModel.delete();
    rxModel.delete();
    waitClk(2);
    bits(8, 0);
    csHigh(0);
    chk("reset_frame_ignored", rxDataPresent, 0);
    frame(8);
    drain();
    flags();
    for (int i = 0; i < DEPTH; i++) begin
      wr(8'(i * 7 + 3));
      if (i == 6) chk("tx_half_7", txHalfFull, 0);
      if (i == 7) chk("tx_half_8", txHalfFull, 1);
      if (i == DEPTH - 2) chk("tx_not_full", txFull, 0);
    end
    chk("tx_full", txFull, 1);
    wr(8'hEE);
    for (int it = 0; it < 20; it++) begin
      int nb, nw;
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      nw = $urandom_range(0, 4);
      for (int k = 0; k < nw; k++) wr(8'($urandom_range(0, 255)));
      nb = $urandom_range(1, 3);
      fillMo(nb);
      if ($urandom_range(0, 4) == 0) begin
        csLow(1);
        bits((nb - 1) * 8 + $urandom_range(1, 7), 1);
        csHigh(1);
      end else frame(nb * 8);
      drain();
      flags();
    end
    chk("miso_pending", expMiso.size(), 0);
    waitClk(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xcvr_spi_slave.md
# xcvr_spi_slave

SPI slave transceiver with TX/RX FIFOs: the responder end of the SPI master transceiver, for FPGA designs that are SPI peripherals to an external host. SCK, MOSI and nCs are asynchronous pins, synchronized and oversampled in the `clk` domain. One byte is received from MOSI and one byte is shifted out on MISO per 8 SCK cycles, MSB first. Bytes move to and from fabric logic through the same 8-bit FIFO interface as the master.

## Interface
- `LOG2_DEPTH`, 4, log2 of depth of each FIFO (TX and RX both use the shared `Fifo` block); must be ≥1.

- `clk` in 1: system clock.
- `nRst` in 1: reset, synchronous, active-low.
- `dataIn` in 8: byte to queue for transmission on MISO.
- `write` in 1: 1-clk strobe, push `dataIn` into TX FIFO.
- `read` in 1: 1-clk strobe, pop RX FIFO.
- `cpol` in 1: SCK idle level. Static while nCs is low.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge. Static while nCs is low.
- `sck` in 1: SPI clock from master, asynchronous.
- `mosi` in 1: master out, slave in, asynchronous.
- `nCs` in 1: chip select from master, active-low, asynchronous.
- `miso` out 1: slave out, master in (registered).
- `misoEn` out 1: output enable for an external MISO tristate; high only while selected.
- `txDataPresent`, `txHalfFull`, `txFull` out 1 each: TX FIFO status.
- `rxDataPresent`, `rxHalfFull`, `rxFull` out 1 each: RX FIFO status.
- `dataOut` out 8: head of RX FIFO.
- `txUnderrun` out 1: 1-clk pulse; a byte was needed but the TX FIFO was empty, so 0x00 was sent.
- `rxOverflow` out 1: 1-clk pulse; a received byte was dropped because the RX FIFO was full.

## Operation
- **Synchronization**
  - `sck`, `mosi` and `nCs` each pass through a 2-flop synchronizer.
  - A third flop on synced `sck` provides edge detection.
- **Edge definitions**
  - Leading edge: synced sck goes from `cpol` to `~cpol`.
  - Trailing edge: the reverse transition.
  - Sample edge: leading edge when `cpha`=0, trailing edge when `cpha`=1.
  - Shift edge: the opposite edge.
- **Frame start** (synced nCs falls while armed):
  - Set `misoEn`=1 and clear the 3-bit bit counter.
  - Load `txShift` with the TX FIFO head and pulse the internal `txRead`. If the TX FIFO is empty, load 0x00 and pulse `txUnderrun`.
  - If `cpha`=0, also set `miso` ← byte[7] and shift `txShift` left 1 in the same cycle.
- **Shift edge**
  - `miso` ← `txShift[7]`.
  - `txShift` ← `txShift` << 1.
- **Sample edge**
  - `rxShift` ← {`rxShift[6:0]`, synced mosi}.
  - Bit counter increments (wraps 7→0).
- **8th sample edge of each byte**
  - Push {`rxShift[6:0]`, mosi} into the RX FIFO via a 1-clk internal `rxWrite`.
  - If `rxFull`, do not push; pulse `rxOverflow` instead.
  - In the same cycle, reload `txShift` with the next TX byte (pop, or 0x00 plus `txUnderrun`).
  - The next shift edge then presents the new MSB. This supports back-to-back bytes with no gap.
- **Frame end** (synced nCs rises)
  - Set `misoEn`=0 and `miso`=0.
  - Discard any partial RX byte (no push) and clear the bit counter.
  - A TX byte already popped for a partial byte is lost; no flag is raised.
- SCK edges while synced nCs is high are ignored.
- **Arming**
  - Armed is set only after synced nCs has been observed high.
  - Reset clears armed, so a frame already in progress at reset release is ignored until nCs goes high.
- **Simultaneous events**
  - A fabric `write` in the same cycle as an internal pop, or a fabric `read` in the same cycle as an internal push, is handled by the FIFO, with no loss.

## Timing
- **Reset** (`nRst`=0 at clk edge):
  - `miso`=0, `misoEn`=0, `txUnderrun`=0, `rxOverflow`=0.
  - Both FIFOs empty: all status flags 0.
  - Bit counter 0, armed=0, synchronizers cleared to idle (nCs=1, sck=`cpol`).
- **Latencies**
  - nCs pin fall → `misoEn`=1: 3 clk.
  - nCs pin fall → `miso` valid (`cpha`=0): 3 clk.
  - sck pin edge → `miso` update: 3 clk.
  - sck pin edge → mosi capture: 3 clk.
  - 8th sample pin edge → `rxDataPresent` high: ≤5 clk.
- **Requirements on the master**
  - SCK frequency ≤ clk/8; each SCK half-period ≥4 clk.
  - nCs fall to first SCK edge ≥4 clk.
  - Last SCK edge to nCs rise ≥4 clk.
  - MOSI must be stable ≥1 clk before and after each sample edge at the pin.
- **Pulses**
  - `txUnderrun` and `rxOverflow` are single-clk pulses, at most one per byte each.

## Test plan
- **Mode 0, one byte:** `write` 0xA5; master (`cpol`=0, `cpha`=0, SCK=clk/8) sends 0x3C → master receives 0xA5; `rxDataPresent`=1; `dataOut`=0x3C; no flags.
- **All four modes, 3 bytes back-to-back:** queue 0x01, 0x80, 0xFF; master sends 0x55, 0xAA, 0x0F → each mode returns 0x01, 0x80, 0xFF; RX FIFO holds 0x55, 0xAA, 0x0F in order.
- **Underrun:** TX FIFO empty, master sends 2 bytes → MISO bytes are 0x00, 0x00; `txUnderrun` pulses twice; RX captures both bytes.
- **Overflow:** fill RX FIFO to 2^LOG2_DEPTH without reading, master sends 0x77 → `rxOverflow` pulses once; FIFO contents unchanged; `rxFull` stays 1.
- **Abort:** master sends 0x5A, then raises nCs after 4 bits → no RX push; `misoEn`=0 within 3 clk. The next full frame with 0xC3 is received as 0xC3.
- **Reset mid-frame:** `nRst` low after 3 bits, released while nCs is still low → no further activity. After nCs goes high and low again, a full frame works normally.
